// File: rtl/conv1d_engine.sv
// conv1d_engine: 1-D discrete convolution z = x * y.
// X and Y are read through synchronous-read ports. One product term is issued
// per cycle, and each finished output sample is written to Z.
// Output shapes are full, same or valid. Saturation of the result is optional.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | check the configuration, work out L/OFF, issue the first term
// ISSUE  | drive one (x_addr, y_addr) pair per cycle for T(n) cycles
// DRAIN  | let the memory/multiply/accumulate pipeline empty
// WRITE  | z_we is high; next sample starts or operation ends
// FIN    | done pulse (error path waits one extra cycle here)
module conv1d_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_X_W = 5,
    parameter int ADDR_Y_W = 5,
    parameter int ADDR_Z_W = 6,
    parameter int ACC_W    = 72,
    parameter int SAT      = 0
) (
    input  logic                clk,
    input  logic                rst_a,
    input  logic                start,
    input  logic [ADDR_X_W:0]   size_x,
    input  logic [ADDR_Y_W:0]   size_y,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_Z_W:0]   z_len,
    output logic [ADDR_X_W-1:0] x_addr,
    input  logic [DATA_W-1:0]   x_data,
    output logic [ADDR_Y_W-1:0] y_addr,
    input  logic [DATA_W-1:0]   y_data,
    output logic [ADDR_Z_W-1:0] z_addr,
    output logic [DATA_W-1:0]   z_data,
    output logic                z_we
);

    // Internal index width. It has headroom for n+1 with n up to nx+ny-2.
    localparam int CW = ADDR_Z_W + 2;
    localparam int DEPTH_X = 2 ** ADDR_X_W;
    localparam int DEPTH_Y = 2 ** ADDR_Y_W;
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_ISSUE, S_DRAIN, S_WRITE, S_FIN
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_nx, r_ny, r_len, r_n, r_k, r_kmax, r_j;
    logic [1:0]           r_mode;
    logic [1:0]           r_drain;
    logic                 r_first;
    logic                 r_busy, r_done, r_err, r_z_we;
    logic [ADDR_Z_W:0]    r_z_len;
    logic [ADDR_X_W-1:0]  r_x_addr;
    logic [ADDR_Y_W-1:0]  r_y_addr;
    logic [ADDR_Z_W-1:0]  r_z_addr;
    logic [DATA_W-1:0]    r_z_data;

    logic                 r_v1, r_f1, r_v2, r_f2;
    logic [2*DATA_W-1:0]  r_prod;
    logic [ACC_W-1:0]     r_acc;

    logic                 w_cfg_err;
    logic [CW-1:0]        w_len, w_off, w_n_sel, w_kmin, w_kmax;
    logic [2*DATA_W-1:0]  w_prod;
    logic [ACC_W-1:0]     w_prod_ext;
    logic                 w_over, w_under;
    logic [DATA_W-1:0]    w_fmt;

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign z_len  = r_z_len;
    assign x_addr = r_x_addr;
    assign y_addr = r_y_addr;
    assign z_addr = r_z_addr;
    assign z_data = r_z_data;
    assign z_we   = r_z_we;

    // Configuration check and output range, evaluated from the latched operands.
    always_comb begin
        w_cfg_err = (r_nx == '0) || (r_ny == '0) ||
                    (r_nx > CW'(DEPTH_X)) || (r_ny > CW'(DEPTH_Y)) ||
                    (r_mode == 2'b11) ||
                    ((r_mode == 2'b10) && (r_ny > r_nx));
        w_len = '0;
        w_off = '0;
        case (r_mode)
            2'b00: begin
                w_len = r_nx + r_ny - CW'(1);
                w_off = '0;
            end
            2'b01: begin
                w_len = r_nx;
                w_off = r_ny >> 1;
            end
            2'b10: begin
                w_len = r_nx - r_ny + CW'(1);
                w_off = r_ny - CW'(1);
            end
            default: begin
                w_len = '0;
                w_off = '0;
            end
        endcase
    end

    // Term range for the sample about to start. That is OFF when leaving INIT,
    // and n+1 when leaving WRITE.
    always_comb begin
        w_n_sel = (r_state == S_INIT) ? w_off : (r_n + CW'(1));
        w_kmin  = ((w_n_sel + CW'(1)) > r_nx) ? (w_n_sel + CW'(1) - r_nx) : '0;
        w_kmax  = (w_n_sel < (r_ny - CW'(1))) ? w_n_sel : (r_ny - CW'(1));
    end

    // Signed product, sign extension and result formatting.
    always_comb begin
        w_prod     = (2*DATA_W)'($signed(x_data)) * (2*DATA_W)'($signed(y_data));
        w_prod_ext = ACC_W'($signed(r_prod));
        w_over     = $signed(r_acc) > $signed(SAT_MAX);
        w_under    = $signed(r_acc) < $signed(SAT_MIN);
        w_fmt      = r_acc[DATA_W-1:0];
        if (SAT != 0) begin
            if (w_over)
                w_fmt = SAT_MAX[DATA_W-1:0];
            else if (w_under)
                w_fmt = SAT_MIN[DATA_W-1:0];
        end
    end

    // Multiply-accumulate pipeline: read data, then product, then accumulate.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            r_v1   <= 1'b0;
            r_f1   <= 1'b0;
            r_v2   <= 1'b0;
            r_f2   <= 1'b0;
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            r_v1   <= (r_state == S_ISSUE);
            r_f1   <= (r_state == S_ISSUE) && r_first;
            r_v2   <= r_v1;
            r_f2   <= r_f1;
            r_prod <= w_prod;
            if (r_v2)
                r_acc <= (r_f2 ? '0 : r_acc) + w_prod_ext;
        end
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            r_state  <= S_IDLE;
            r_nx     <= '0;
            r_ny     <= '0;
            r_mode   <= '0;
            r_len    <= '0;
            r_n      <= '0;
            r_k      <= '0;
            r_kmax   <= '0;
            r_j      <= '0;
            r_drain  <= '0;
            r_first  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_z_we   <= 1'b0;
            r_z_len  <= '0;
            r_x_addr <= '0;
            r_y_addr <= '0;
            r_z_addr <= '0;
            r_z_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nx    <= CW'(size_x);
                        r_ny    <= CW'(size_y);
                        r_mode  <= mode;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (w_cfg_err) begin
                        r_err   <= 1'b1;
                        r_z_len <= '0;
                        r_state <= S_FIN;
                    end else begin
                        r_len    <= w_len;
                        r_j      <= '0;
                        r_n      <= w_n_sel;
                        r_k      <= w_kmin;
                        r_kmax   <= w_kmax;
                        r_x_addr <= ADDR_X_W'(w_n_sel - w_kmin);
                        r_y_addr <= ADDR_Y_W'(w_kmin);
                        r_first  <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_first <= 1'b0;
                    if (r_k == r_kmax) begin
                        r_drain <= 2'd2;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k      <= r_k + CW'(1);
                        r_x_addr <= r_x_addr - ADDR_X_W'(1);
                        r_y_addr <= r_y_addr + ADDR_Y_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 2'd0) begin
                        r_z_we   <= 1'b1;
                        r_z_data <= w_fmt;
                        r_z_addr <= ADDR_Z_W'(r_j);
                        r_state  <= S_WRITE;
                    end else begin
                        r_drain <= r_drain - 2'd1;
                    end
                end
                S_WRITE: begin
                    r_z_we <= 1'b0;
                    if ((r_j + CW'(1)) == r_len) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_z_len <= (ADDR_Z_W+1)'(r_len);
                        r_state <= S_FIN;
                    end else begin
                        r_j      <= r_j + CW'(1);
                        r_n      <= w_n_sel;
                        r_k      <= w_kmin;
                        r_kmax   <= w_kmax;
                        r_x_addr <= ADDR_X_W'(w_n_sel - w_kmin);
                        r_y_addr <= ADDR_Y_W'(w_kmin);
                        r_first  <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_FIN: begin
                    // Normal path arrives with done already raised; the error
                    // path raises it here, one cycle later.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_engine.sv
// Bench for conv1d_engine. Two instances (truncating and saturating) share the
// X/Y memories. Expected Z samples are queued at start and popped on z_we.
module tb_conv1d_engine;

    localparam int DW = 32;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        start0, start1;
    logic [5:0]  size_x, size_y;
    logic [1:0]  mode;

    logic        busy0, done0, err0, zwe0, busy1, done1, err1, zwe1;
    logic [6:0]  zlen0, zlen1;
    logic [4:0]  xa0, ya0, xa1, ya1;
    logic [5:0]  za0, za1;
    logic [31:0] zd0, zd1, xd0, yd0, xd1, yd1;

    logic [31:0] mem_x [0:31];
    logic [31:0] mem_y [0:31];

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int first_we = -1;
    int last_we = -1;
    bit sel = 1'b0;

    logic w_busy, w_done, w_err, w_zwe;
    logic [6:0] w_zlen;

    always #5 clk = ~clk;

    conv1d_engine #(.SAT(0)) u_dut (
        .clk(clk), .rst_a(rst_a), .start(start0), .size_x(size_x), .size_y(size_y),
        .mode(mode), .busy(busy0), .done(done0), .err(err0), .z_len(zlen0),
        .x_addr(xa0), .x_data(xd0), .y_addr(ya0), .y_data(yd0),
        .z_addr(za0), .z_data(zd0), .z_we(zwe0)
    );

    conv1d_engine #(.SAT(1)) u_sat (
        .clk(clk), .rst_a(rst_a), .start(start1), .size_x(size_x), .size_y(size_y),
        .mode(mode), .busy(busy1), .done(done1), .err(err1), .z_len(zlen1),
        .x_addr(xa1), .x_data(xd1), .y_addr(ya1), .y_data(yd1),
        .z_addr(za1), .z_data(zd1), .z_we(zwe1)
    );

    assign w_busy = sel ? busy1 : busy0;
    assign w_done = sel ? done1 : done0;
    assign w_err  = sel ? err1  : err0;
    assign w_zwe  = sel ? zwe1  : zwe0;
    assign w_zlen = sel ? zlen1 : zlen0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        xd0 <= mem_x[xa0];
        yd0 <= mem_y[ya0];
        xd1 <= mem_x[xa1];
        yd1 <= mem_y[ya1];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (zwe0) begin
            chk("q0_has_entry", 64'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("z_addr0", 64'(za0), 64'(e0.a));
                chk("z_data0", 64'(zd0), 64'(e0.d));
            end
            if (!sel) begin
                if (first_we < 0) first_we = cyc - t0;
                last_we = cyc - t0;
            end
        end
        if (zwe1) begin
            chk("q1_has_entry", 64'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("z_addr1", 64'(za1), 64'(e1.a));
                chk("z_data1", 64'(zd1), 64'(e1.d));
            end
            if (sel) begin
                if (first_we < 0) first_we = cyc - t0;
                last_we = cyc - t0;
            end
        end
    end

    function automatic int ref_len(input int nx, input int ny, input int md);
        if (md == 0) return nx + ny - 1;
        if (md == 1) return nx;
        return nx - ny + 1;
    endfunction

    // Direct convolution sum over all k, for independence from the DUT's term bounds.
    function automatic logic [31:0] ref_z(input int nx, input int ny, input int md,
                                          input int j, input bit sat);
        int off;
        int n;
        longint acc;
        logic [63:0] acc_v;
        off = (md == 0) ? 0 : ((md == 1) ? ny / 2 : ny - 1);
        n = j + off;
        acc = 0;
        for (int k = 0; k < ny; k++) begin
            if ((n - k) >= 0 && (n - k) < nx)
                acc += longint'($signed(mem_x[n-k])) * longint'($signed(mem_y[k]));
        end
        if (sat) begin
            if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
            if (acc < -64'sd2147483648) return 32'h8000_0000;
        end
        acc_v = acc;
        return acc_v[31:0];
    endfunction

    task automatic run_op(input int nx, input int ny, input int md, input bit use_sat,
                          input bit exp_err, input int exp_done, input int exp_first,
                          input int exp_last, input int glitch_at, input int rst_at);
        int rel;
        int len;
        bit got_done;
        bit aborted;
        bit saw_done;
        exp_t e;
        sel = use_sat;
        first_we = -1;
        last_we = -1;
        len = exp_err ? 0 : ref_len(nx, ny, md);
        for (int j = 0; j < len; j++) begin
            e.a = 6'(j);
            e.d = ref_z(nx, ny, md, j, use_sat);
            if (use_sat) q1.push_back(e);
            else q0.push_back(e);
        end
        @(negedge clk);
        size_x = 6'(nx);
        size_y = 6'(ny);
        mode = 2'(md);
        if (use_sat) start1 = 1'b1;
        else start0 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        rel = 1;
        got_done = 1'b0;
        aborted = 1'b0;
        while (rel < 6000 && !got_done && !aborted) begin
            if (rel == 1) chk("busy_on", 64'(w_busy), 1);
            if (glitch_at > 0 && rel == glitch_at) begin
                size_x = 6'd1;
                size_y = 6'd1;
                mode = 2'b10;
                if (use_sat) start1 = 1'b1;
                else start0 = 1'b1;
            end
            if (glitch_at > 0 && rel == glitch_at + 1) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if (rst_at > 0 && rel == rst_at) begin
                rst_a = 1'b1;
                q0.delete();
                q1.delete();
            end
            if (rst_at > 0 && rel == rst_at + 1) begin
                chk("rst_busy", 64'(w_busy), 0);
                chk("rst_zwe", 64'(w_zwe), 0);
                chk("rst_done", 64'(w_done), 0);
                rst_a = 1'b0;
                aborted = 1'b1;
            end else if (w_done) begin
                got_done = 1'b1;
            end
            if (!got_done && !aborted) begin
                @(negedge clk);
                rel++;
            end
        end
        if (aborted) begin
            saw_done = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (w_done || w_busy) saw_done = 1'b1;
            end
            chk("no_done_after_rst", 64'(saw_done), 0);
        end else begin
            chk("done_seen", 64'(got_done), 1);
            if (got_done) begin
                if (exp_done > 0) chk("done_cycle", 64'(rel), 64'(exp_done));
                if (exp_first > 0) chk("first_we", 64'(first_we), 64'(exp_first));
                if (exp_last > 0) chk("last_we", 64'(last_we), 64'(exp_last));
                chk("busy_off", 64'(w_busy), 0);
                chk("err", 64'(w_err), 64'(exp_err));
                chk("z_len", 64'(w_zlen), 64'(len));
                chk("queue_empty", 64'(use_sat ? q1.size() : q0.size()), 0);
                @(negedge clk);
                chk("done_pulse", 64'(w_done), 0);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        size_x = '0;
        size_y = '0;
        mode = '0;
        for (int i = 0; i < 32; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy0", 64'(busy0), 0);
        chk("rst_done0", 64'(done0), 0);
        chk("rst_err0", 64'(err0), 0);
        chk("rst_zwe0", 64'(zwe0), 0);
        chk("rst_zlen0", 64'(zlen0), 0);
        chk("rst_addr0", 64'({xa0, ya0, za0}), 0);
        chk("rst_zdata0", 64'(zd0), 0);
        rst_a = 1'b0;
        @(negedge clk);

        mem_x[0] = 1; mem_x[1] = 2; mem_x[2] = 3; mem_x[3] = 4;
        mem_y[0] = 1; mem_y[1] = 1; mem_y[2] = 1;
        run_op(4, 3, 0, 0, 0, 38, 6, 37, -1, -1);
        run_op(4, 3, 1, 0, 0, 0, 0, 0, -1, -1);
        run_op(4, 3, 2, 0, 0, 0, 0, 0, -1, -1);
        run_op(2, 3, 2, 0, 1, 3, 0, 0, -1, -1);
        run_op(4, 3, 3, 0, 1, 3, 0, 0, -1, -1);
        run_op(4, 0, 0, 0, 1, 3, 0, 0, -1, -1);

        mem_x[0] = 32'hFFFF_FFFD;
        mem_y[0] = 32'd5;
        run_op(1, 1, 0, 0, 0, 0, 0, 0, -1, -1);

        mem_x[0] = 32'h7FFF_FFFF; mem_x[1] = 32'h7FFF_FFFF;
        mem_y[0] = 32'd2;
        run_op(2, 1, 0, 1, 0, 0, 0, 0, -1, -1);
        run_op(2, 1, 0, 0, 0, 0, 0, 0, -1, -1);

        mem_x[0] = 1; mem_x[1] = 2; mem_x[2] = 3; mem_x[3] = 4;
        mem_y[0] = 1; mem_y[1] = 1; mem_y[2] = 1;
        run_op(4, 3, 0, 0, 0, 38, 6, 37, 10, -1);
        run_op(4, 3, 0, 0, 0, 0, 0, 0, -1, 20);

        for (int i = 0; i < 32; i++) begin
            mem_x[i] = $urandom;
            mem_y[i] = $urandom;
        end
        run_op(32, 32, 0, 0, 0, 0, 0, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
